// File: rtl/ad7276_frame_scheduler.sv
// AD7276 array sequencer: periodic conversion start, EOC collection, coherent snapshot, AXIS frame out.
// Optional EOC watchdog is compiled in with `define AD7276_SCHED_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a period tick
// TRIG     | conv_start pulse, EOC tracking cleared
// WAIT_EOC | collecting EOC pulses from every instance
// CAPTURE  | snapshot all channel results
// STREAM   | one AXIS beat per channel, tlast on the final channel
module ad7276_frame_scheduler #(
  parameter int ADC_LENGTH  = 12,
  parameter int ADC_QTD     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                              CLK100MHz,
  input  logic                              ARESET,
  input  logic                              enable,
  input  logic [31:0]                       rate_div,
  input  logic                              err_clr,
  input  logic [2*ADC_QTD*ADC_LENGTH-1:0]   adc_data,
  input  logic [ADC_QTD-1:0]                eoc_adc,
  output logic                              conv_start,
  output logic [15:0]                       m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic                              overrun,
  output logic                              timeout_err
);

  localparam int NCH = 2 * ADC_QTD;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_EOC, CAPTURE, STREAM} state_t;

  state_t                      state, state_nx;
  logic [31:0]                 per_cnt, per_lim, rate_eff;
  logic                        tick;
  logic [ADC_QTD-1:0]          eoc_seen, seen_nx;
  logic                        all_seen, last_ch, wd_expire;
  logic [NCH*ADC_LENGTH-1:0]   shadow;
  logic [3:0]                  ch;

  assign rate_eff = (rate_div < 32'd2) ? 32'd2 : rate_div;
  assign tick     = enable && (per_cnt == per_lim - 32'd1);
  assign seen_nx  = eoc_seen | eoc_adc;
  assign all_seen = &seen_nx;
  assign last_ch  = (ch == 4'(NCH - 1));
  assign busy     = (state != IDLE);

  // The limit is latched on every reload so a rate_div change never truncates a running period.
  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      per_cnt <= '0;
      per_lim <= 32'd2;
    end else if (!enable || tick) begin
      per_cnt <= '0;
      per_lim <= rate_eff;
    end else begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    conv_start    = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      IDLE:     if (tick) state_nx = TRIG;
      TRIG: begin
        conv_start = 1'b1;
        state_nx   = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (all_seen)       state_nx = CAPTURE;
        else if (wd_expire) state_nx = IDLE;
      end
      CAPTURE:  state_nx = STREAM;
      STREAM: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready && last_ch) state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      eoc_seen <= '0;
      shadow   <= '0;
      ch       <= '0;
    end else begin
      if (state == TRIG)     eoc_seen <= '0;
      if (state == WAIT_EOC) eoc_seen <= seen_nx;
      if (state == CAPTURE) begin
        shadow <= adc_data;
        ch     <= '0;
      end
      if (state == STREAM && m_axis_tready && !last_ch) ch <= ch + 4'd1;
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    if (state == STREAM) begin
      m_axis_tdata[15:12]          = ch;
      m_axis_tdata[ADC_LENGTH-1:0] = shadow[int'(ch)*ADC_LENGTH +: ADC_LENGTH];
      m_axis_tlast                 = last_ch;
    end
  end

  // Set has priority over err_clr so an error in the clearing cycle is not lost.
  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET)                       overrun <= 1'b0;
    else if (tick && state != IDLE)   overrun <= 1'b1;
    else if (err_clr)                 overrun <= 1'b0;
  end

`ifdef AD7276_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign wd_expire = (state == WAIT_EOC) && !all_seen && (wd_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK100MHz or posedge ARESET) begin
    if (ARESET) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT_EOC) ? wd_cnt + 32'd1 : '0;
      if (wd_expire)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
